// File: rtl/framing_512_fifo.sv
// framing_512_fifo: single-clock FIFO, 2**DEPTH_WIDTH words x DATA_WIDTH bits. It holds one
// audio frame between the sample producer and the frame processor.
//
// Ports
//   clk            in   rising-edge clock for all logic
//   rst_n          in   asynchronous active-low reset; discards contents
//   wr_data        in   word to write
//   wr_en          in   write request, ignored while wr_full
//   wr_full        out  FIFO holds 2**DEPTH_WIDTH words
//   wr_water_level out  occupancy, 0..2**DEPTH_WIDTH
//   almost_full    out  occupancy >= ALMOST_FULL_NUM
//   rd_data        out  read word, 1 clk after an accepted read (2 clks with OUTPUT_REG=1)
//   rd_en          in   read request, ignored while rd_empty
//   rd_empty       out  FIFO holds no words
//   rd_water_level out  occupancy, same as wr_water_level
//   almost_empty   out  occupancy <= ALMOST_EMPTY_NUM
module framing_512_fifo #(
    parameter int unsigned DEPTH_WIDTH      = 9,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned OUTPUT_REG       = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 508,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic [DEPTH_WIDTH:0]   wr_water_level,
    output logic                   almost_full,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_en,
    output logic                   rd_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level,
    output logic                   almost_empty
);

    localparam int unsigned Depth = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FullLevel = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [DEPTH_WIDTH:0] AfLevel   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AeLevel   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0] LevelOne  = (DEPTH_WIDTH + 1)'(1);
    localparam logic [DEPTH_WIDTH-1:0] PtrOne  = DEPTH_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  mem [Depth];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_WIDTH:0]   count_q, count_d;
    logic                   full_q, empty_q, afull_q, aempty_q;
    logic [DATA_WIDTH-1:0]  rd_stage_q;
    logic                   wr_accept, rd_accept;

    // Acceptance uses the registered flags, so a full FIFO drops writes and an empty FIFO
    // drops reads even when the other side is active in the same cycle.
    assign wr_accept = wr_en && !full_q;
    assign rd_accept = rd_en && !empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + LevelOne;
            2'b01:   count_d = count_q - LevelOne;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_stage_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_accept) begin
                rd_ptr_q   <= rd_ptr_q + PtrOne;
                rd_stage_q <= mem[rd_ptr_q];
            end
            count_q  <= count_d;
            full_q   <= (count_d == FullLevel);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AfLevel);
            aempty_q <= (count_d <= AeLevel);
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= rd_stage_q;
                end
            end
            assign rd_data = out_q;
        end else begin : g_no_out_reg
            assign rd_data = rd_stage_q;
        end
    endgenerate

    assign wr_full        = full_q;
    assign rd_empty       = empty_q;
    assign almost_full    = afull_q;
    assign almost_empty   = aempty_q;
    assign wr_water_level = count_q;
    assign rd_water_level = count_q;

endmodule

// File: tb/tb_framing_512_fifo.sv
// Directed bench for framing_512_fifo (default parameters, OUTPUT_REG=0).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_framing_512_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic [9:0]  wr_water_level;
    logic        almost_full;
    logic [15:0] rd_data;
    logic        rd_en;
    logic        rd_empty;
    logic [9:0]  rd_water_level;
    logic        almost_empty;

    int passed = 0;
    int total  = 0;
    int exp_lvl = 0;

    framing_512_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rd_empty"}, 32'(rd_empty), 32'd1);
        check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, " wr_full"}, 32'(wr_full), 32'd0);
        check({tag, " almost_full"}, 32'(almost_full), 32'd0);
        check({tag, " wr_level"}, 32'(wr_water_level), 32'd0);
        check({tag, " rd_level"}, 32'(rd_water_level), 32'd0);
        check({tag, " rd_data"}, 32'(rd_data), 32'd0);
    endtask

    // One clock: drive requests, let the rising edge happen, then compare on the falling edge.
    // exp_rd is the rd_data value the caller expects after this edge.
    task automatic cycle(input string tag, input bit w, input logic [15:0] wd, input bit r,
                         input logic [15:0] exp_rd);
        bit wa, ra;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        wa = w && (exp_lvl != 512);
        ra = r && (exp_lvl != 0);
        exp_lvl = exp_lvl + int'(wa) - int'(ra);
        @(negedge clk);
        check({tag, " wr_level"}, 32'(wr_water_level), 32'(exp_lvl));
        check({tag, " rd_level"}, 32'(rd_water_level), 32'(exp_lvl));
        check({tag, " wr_full"}, 32'(wr_full), 32'(exp_lvl == 512));
        check({tag, " rd_empty"}, 32'(rd_empty), 32'(exp_lvl == 0));
        check({tag, " almost_full"}, 32'(almost_full), 32'(exp_lvl >= 508));
        check({tag, " almost_empty"}, 32'(almost_empty), 32'(exp_lvl <= 4));
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        // Reset held for 200 ns.
        #200;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 0xFFFF downwards; the 513th word (0xFDFF) hits a full FIFO and is dropped.
        for (int i = 0; i < 513; i++) begin
            cycle("fill", 1'b1, 16'hFFFF - 16'(i), 1'b0, 16'h0000);
        end

        // Drain; the 513th read finds the FIFO empty and rd_data holds 0xFE00.
        for (int i = 0; i < 513; i++) begin
            cycle("drain", 1'b0, 16'h0000, 1'b1, (i < 512) ? 16'hFFFF - 16'(i) : 16'hFE00);
        end

        // Simultaneous read/write at level 100.
        for (int k = 0; k < 100; k++) begin
            cycle("lvl100_fill", 1'b1, 16'h1000 + 16'(k), 1'b0, 16'hFE00);
        end
        for (int k = 0; k < 50; k++) begin
            cycle("rdwr", 1'b1, 16'h1064 + 16'(k), 1'b1, 16'h1000 + 16'(k));
        end
        for (int k = 0; k < 100; k++) begin
            cycle("rdwr_drain", 1'b0, 16'h0000, 1'b1, 16'h1032 + 16'(k));
        end

        // Pointer wrap: pointers start at 150, so the 400-word burst crosses 511->0.
        for (int k = 0; k < 300; k++) begin
            cycle("wrap_w300", 1'b1, 16'h2000 + 16'(k), 1'b0, 16'h1095);
        end
        for (int k = 0; k < 300; k++) begin
            cycle("wrap_r300", 1'b0, 16'h0000, 1'b1, 16'h2000 + 16'(k));
        end
        for (int k = 0; k < 400; k++) begin
            cycle("wrap_w400", 1'b1, 16'h3000 + 16'(k), 1'b0, 16'h212B);
        end
        for (int k = 0; k < 400; k++) begin
            cycle("wrap_r400", 1'b0, 16'h0000, 1'b1, 16'h3000 + 16'(k));
        end

        // Simultaneous request on an empty FIFO: only the write is taken.
        cycle("empty_rdwr", 1'b1, 16'h6666, 1'b1, 16'h318F);
        cycle("empty_rdwr_rd", 1'b0, 16'h0000, 1'b1, 16'h6666);

        // Reset mid-fill at level 200; outputs must clear without waiting for a clock edge.
        for (int k = 0; k < 200; k++) begin
            cycle("prefill", 1'b1, 16'h4000 + 16'(k), 1'b0, 16'h6666);
        end
        wr_en = 1'b1;
        wr_data = 16'h4FFF;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wr_en = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset_held");
        rst_n = 1'b1;
        exp_lvl = 0;

        // Old contents discarded: the next word out is the one written after reset.
        cycle("post_rst_w", 1'b1, 16'h5555, 1'b0, 16'h0000);
        cycle("post_rst_r", 1'b0, 16'h0000, 1'b1, 16'h5555);
        cycle("post_rst_empty", 1'b0, 16'h0000, 1'b1, 16'h5555);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
